// File: rtl/hc194_usr_latch.sv
// WIDTH-bit 74HC194-style universal shift register with 595-style storage latch.
// Define HC194_USR_PARITY_EN to add the registered par_out output.
module hc194_usr_latch #(
  parameter int              WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  localparam int             CW      = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic             dsr,
  input  logic             dsl,
  input  logic [WIDTH-1:0] d_in,
  input  logic             latch,
  output logic [WIDTH-1:0] q_out,
  output logic             so_up,
  output logic             so_dn,
  output logic [CW-1:0]    shift_cnt,
`ifdef HC194_USR_PARITY_EN
  output logic             par_out,
`endif
  output logic             done
);

  localparam logic [CW-1:0] WRAP = CW'(WIDTH);

  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] sreg_nx;
  logic [CW-1:0]    cnt_nx;
  logic [CW-1:0]    cnt_inc;
  logic             done_nx;
  logic             shifting;

  always_comb begin
    sreg_nx  = sreg;
    cnt_nx   = shift_cnt;
    done_nx  = 1'b0;
    shifting = 1'b0;
    cnt_inc  = shift_cnt + CW'(1);
    case (mode)
      2'b01: begin
        sreg_nx  = {sreg[WIDTH-2:0], dsr};
        shifting = 1'b1;
      end
      2'b10: begin
        sreg_nx  = {dsl, sreg[WIDTH-1:1]};
        shifting = 1'b1;
      end
      2'b11: begin
        sreg_nx = d_in;
        cnt_nx  = '0;
      end
      default: ;
    endcase
    // a frame closes on the WIDTH-th shift in either direction
    if (shifting) begin
      if (cnt_inc == WRAP) begin
        cnt_nx  = '0;
        done_nx = 1'b1;
      end else begin
        cnt_nx = cnt_inc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sreg      <= RST_VAL;
      q_out     <= RST_VAL;
      shift_cnt <= '0;
      done      <= 1'b0;
`ifdef HC194_USR_PARITY_EN
      par_out   <= ^RST_VAL;
`endif
    end else begin
      sreg      <= sreg_nx;
      shift_cnt <= cnt_nx;
      done      <= done_nx;
      // storage captures the pre-edge shift register
      if (latch) begin
        q_out   <= sreg;
`ifdef HC194_USR_PARITY_EN
        par_out <= ^sreg;
`endif
      end
    end
  end

  assign so_up = sreg[WIDTH-1];
  assign so_dn = sreg[0];

endmodule

// File: tb/tb_hc194_usr_latch.sv
// Bench for hc194_usr_latch: arithmetic reference model plus directed vectors.
// Outputs are compared against the model every negedge after the first reset.
module tb_hc194_usr_latch;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] mode = 2'b00;
  logic       dsr = 1'b0;
  logic       dsl = 1'b0;
  logic [7:0] d_in = 8'h00;
  logic       latch = 1'b0;
  logic [7:0] q_out;
  logic       so_up;
  logic       so_dn;
  logic [3:0] shift_cnt;
  logic       done;
`ifdef HC194_USR_PARITY_EN
  logic       par_out;
`endif

  hc194_usr_latch #(.WIDTH(8), .RST_VAL(8'h00)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .dsr       (dsr),
    .dsl       (dsl),
    .d_in      (d_in),
    .latch     (latch),
    .q_out     (q_out),
    .so_up     (so_up),
    .so_dn     (so_dn),
    .shift_cnt (shift_cnt),
`ifdef HC194_USR_PARITY_EN
    .par_out   (par_out),
`endif
    .done      (done)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  bit mvalid = 1'b0;

  int m_sreg = 0;
  int m_q = 0;
  int m_cnt = 0;
  int m_done = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int parity8(input int v);
    int p = 0;
    for (int i = 0; i < 8; i++) p ^= (v >> i) & 1;
    return p;
  endfunction

  // one clock: drive at negedge, advance the model at the edge
  task automatic cyc(input bit r, input int md, input bit sr, input bit sl,
                     input int d, input bit lt);
    @(negedge clk);
    rst = r; mode = 2'(md); dsr = sr; dsl = sl; d_in = 8'(d); latch = lt;
    @(posedge clk);
    if (r) begin
      m_sreg = 0; m_q = 0; m_cnt = 0; m_done = 0;
    end else begin
      if (lt) m_q = m_sreg;
      m_done = 0;
      if (md == 1 || md == 2) begin
        if (md == 1) m_sreg = ((m_sreg * 2) + sr) % 256;
        else         m_sreg = (m_sreg / 2) + (sl ? 128 : 0);
        m_cnt = m_cnt + 1;
        if (m_cnt == 8) begin
          m_cnt = 0;
          m_done = 1;
        end
      end else if (md == 3) begin
        m_sreg = d % 256;
        m_cnt = 0;
      end
    end
    mvalid = 1'b1;
    #1;
  endtask

  always @(negedge clk) begin
    if (mvalid) begin
      chk("q_out", int'(q_out), m_q);
      chk("so_up", int'(so_up), (m_sreg >> 7) & 1);
      chk("so_dn", int'(so_dn), m_sreg & 1);
      chk("shift_cnt", int'(shift_cnt), m_cnt);
      chk("done", int'(done), m_done);
`ifdef HC194_USR_PARITY_EN
      chk("par_out", int'(par_out), parity8(m_q));
`endif
    end
  end

  initial begin
    // 1: reset dominates load and latch
    cyc(1, 3, 0, 0, 'hA5, 1);
    cyc(1, 3, 0, 0, 'hA5, 1);
    chk("rst q_out", int'(q_out), 'h00);
    chk("rst cnt", int'(shift_cnt), 0);
    chk("rst done", int'(done), 0);
    chk("rst so_up", int'(so_up), 0);
    chk("rst so_dn", int'(so_dn), 0);

    // 2: load then latch
    cyc(0, 3, 0, 0, 'hA5, 0);
    chk("t2 q before latch", int'(q_out), 'h00);
    cyc(0, 0, 0, 0, 'h00, 1);
    chk("t2 q_out", int'(q_out), 'hA5);
    chk("t2 so_up", int'(so_up), 1);
    chk("t2 so_dn", int'(so_dn), 1);

    // 3: full frame of shift-up
    cyc(0, 3, 0, 0, 'h00, 0);
    for (int i = 0; i < 8; i++) begin
      cyc(0, 1, 1, 0, 'h00, 0);
      chk("t3 cnt", int'(shift_cnt), (i + 1) % 8);
      chk("t3 done", int'(done), (i == 7) ? 1 : 0);
    end
    cyc(0, 0, 0, 0, 'h00, 1);
    chk("t3 done gone", int'(done), 0);
    chk("t3 q_out", int'(q_out), 'hFF);

    // 4: shift-down then load clears the count
    cyc(0, 3, 0, 0, 'h81, 0);
    cyc(0, 2, 0, 0, 'h00, 0);
    chk("t4 so_dn", int'(so_dn), 0);
    chk("t4 so_up", int'(so_up), 0);
    chk("t4 cnt", int'(shift_cnt), 1);
    cyc(0, 0, 0, 0, 'h00, 1);
    chk("t4 q_out", int'(q_out), 'h40);
    cyc(0, 3, 0, 0, 'h3C, 0);
    chk("t4 cnt cleared", int'(shift_cnt), 0);

    // 5: latch and shift in the same cycle
    cyc(0, 3, 0, 0, 'h01, 0);
    cyc(0, 1, 0, 0, 'h00, 1);
    chk("t5 q_out old", int'(q_out), 'h01);
    chk("t5 so_dn", int'(so_dn), 0);
    cyc(0, 0, 0, 0, 'h00, 1);
    chk("t5 q_out new", int'(q_out), 'h02);

    // load with latch captures the old register
    cyc(0, 3, 0, 0, 'h5A, 1);
    chk("ld+latch q", int'(q_out), 'h02);
    cyc(0, 0, 0, 0, 'h00, 1);
    chk("ld+latch later", int'(q_out), 'h5A);

    // mixed-direction frame still closes after 8 shifts
    for (int i = 0; i < 8; i++) begin
      cyc(0, (i % 2 == 0) ? 1 : 2, 1, 0, 'h00, 0);
      chk("mix done", int'(done), (i == 7) ? 1 : 0);
    end

    // 6: reset mid-frame drops the partial count
    cyc(0, 3, 0, 0, 'h00, 0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 1, 0, 'h00, 0);
    cyc(1, 1, 1, 0, 'h00, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 1, 1, 0, 'h00, 0);
      chk("t6 no done", int'(done), 0);
    end
    chk("t6 cnt", int'(shift_cnt), 5);
    cyc(0, 3, 0, 0, 'h07, 0);
    cyc(0, 0, 0, 0, 'h00, 1);
    chk("t6 q_out", int'(q_out), 'h07);
`ifdef HC194_USR_PARITY_EN
    chk("t6 par_out", int'(par_out), 1);
`endif

    cyc(0, 0, 0, 0, 'h00, 0);
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
